// File: rtl/fp_wb_sequencer.sv
// ---------------------------------------------------------------------------
// fp_wb_sequencer
//
// Write-side sequencer for the floating-point register file. Results from the
// multi-cycle FPU are queued in a small FIFO. Results from the FP load path
// are not buffered. A single winner per cycle goes into a one-deep write stage
// that drives the register file's only write port. A per-register pending
// scoreboard lets issue logic stall on RAW/WAW hazards.
//
// Arbitration: a load beats the FIFO head. A 2-bit starvation counter counts
// the loads that win while the FIFO holds data. When the counter reaches 3 the
// load port is closed for one cycle and the FIFO head is written instead.
//
// Optional feature (macro FP_WB_BYPASS_EN): when the FIFO is empty and no load
// is accepted, an incoming FPU result goes straight to the write stage without
// entering the FIFO. This saves one cycle of latency.
//
// Parameters:
//   DEPTH  FPU result FIFO entries (power of two, >= 2)
//   XLEN   data width
//
// Ports:
//   clk_i             clock
//   rst_ni            asynchronous active-low reset
//   fpu_valid_i/fpu_ready_o/fpu_rd_i/fpu_data_i   FPU result handshake
//   ld_valid_i/ld_ready_o/ld_rd_i/ld_data_i       FP load handshake
//   issue_valid_i/issue_rd_i                      FP-writing instruction issue
//   busy_o            pending-write bit per FP register
//   fregwrite_o/frd_o/writeback_data_o            register-file write port
// ---------------------------------------------------------------------------
module fp_wb_sequencer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            fpu_valid_i,
    output logic            fpu_ready_o,
    input  logic [4:0]      fpu_rd_i,
    input  logic [XLEN-1:0] fpu_data_i,

    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [XLEN-1:0] ld_data_i,

    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,

    output logic [31:0]     busy_o,

    output logic            fregwrite_o,
    output logic [4:0]      frd_o,
    output logic [XLEN-1:0] writeback_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0] STARVE_MAX = 2'd3;

    // Saturating increment of the starvation counter. The counter cannot
    // actually pass 3, because the load port is closed at 3. The saturation
    // keeps the counter from wrapping to 0 if that ever changed.
    function automatic logic [1:0] starve_inc(input logic [1:0] s);
        return (s == STARVE_MAX) ? s : s + 2'd1;
    endfunction

    // FIFO storage and control
    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q,  count_d;
    logic             fifo_empty;

    // Arbitration state
    logic [1:0] starve_q, starve_d;

    // Handshake decisions for the current cycle
    logic ld_take;
    logic fpu_take;
    logic bypass;
    logic enq;
    logic deq;

    // Arbitration winner (stage 0, combinational)
    logic            win_vld_p0;
    logic [4:0]      win_rd_p0;
    logic [XLEN-1:0] win_data_p0;

    // Write stage (stage 1, registered, drives the register-file port)
    logic            wb_vld_p1;
    logic [4:0]      wb_rd_p1;
    logic [XLEN-1:0] wb_data_p1;

    // Scoreboard
    logic [31:0] busy_q, busy_d;

    // Handshakes. Both ready signals come from registered state only.
    assign fifo_empty  = (count_q == '0);
    assign fpu_ready_o = (count_q < FULL_CNT);
    assign ld_ready_o  = (starve_q != STARVE_MAX);

    assign ld_take  = ld_valid_i  && ld_ready_o;
    assign fpu_take = fpu_valid_i && fpu_ready_o;

`ifdef FP_WB_BYPASS_EN
    // The result goes to the write stage directly. It is still a completed
    // FPU handshake, but nothing is written into the FIFO.
    assign bypass = fifo_empty && fpu_valid_i && !ld_take;
`else
    assign bypass = 1'b0;
`endif

    assign enq = fpu_take && !bypass;
    // The FIFO head is dequeued exactly when it wins arbitration.
    assign deq = !fifo_empty && !ld_take;

    // ---- stage 0: arbitration ----
    always_comb begin
        win_vld_p0  = 1'b0;
        win_rd_p0   = rd_mem[rd_ptr_q];
        win_data_p0 = data_mem[rd_ptr_q];
        if (ld_take) begin
            win_vld_p0  = 1'b1;
            win_rd_p0   = ld_rd_i;
            win_data_p0 = ld_data_i;
        end else if (!fifo_empty) begin
            win_vld_p0  = 1'b1;
        end else if (bypass) begin
            win_vld_p0  = 1'b1;
            win_rd_p0   = fpu_rd_i;
            win_data_p0 = fpu_data_i;
        end
    end

    // The counter counts a load win only while FIFO data is waiting. A FIFO
    // win (including a bypass, which needs an empty FIFO) resets it.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty) begin
            starve_d = 2'd0;
        end else if (ld_take) begin
            starve_d = starve_inc(starve_q);
        end else begin
            starve_d = 2'd0;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A write clears its register's bit. An issue in the same cycle sets the
    // bit again, because that issue has a newer write still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wb_vld_p1) begin
            busy_d[wb_rd_p1] = 1'b0;
        end
        if (issue_valid_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    // FIFO payload storage. This is data only, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            rd_mem[wr_ptr_q]   <= fpu_rd_i;
            data_mem[wr_ptr_q] <= fpu_data_i;
        end
    end

    // FIFO control and arbitration state. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= 2'd0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // ---- stage 1: register-file write stage ----
    // Address and data hold their values in idle cycles. The whole stage is
    // reset so that an in-flight write is dropped the moment reset asserts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_vld_p1  <= 1'b0;
            wb_rd_p1   <= 5'd0;
            wb_data_p1 <= '0;
        end else begin
            wb_vld_p1 <= win_vld_p0;
            if (win_vld_p0) begin
                wb_rd_p1   <= win_rd_p0;
                wb_data_p1 <= win_data_p0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign fregwrite_o      = wb_vld_p1;
    assign frd_o            = wb_rd_p1;
    assign writeback_data_o = wb_data_p1;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_fp_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fp_wb_sequencer
//
// Self-checking bench for fp_wb_sequencer. FPU and load sources are queues of
// pending transfers. Each source drives its head and holds it until the
// transfer is accepted. A behavioural model of the FIFO, the arbiter and the
// scoreboard decides each cycle's winner and pushes the expected write into a
// scoreboard queue. The queue is popped and compared when the write stage
// shows it.
// ---------------------------------------------------------------------------
module tb_fp_wb_sequencer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fpu_valid;
    logic            fpu_ready;
    logic [4:0]      fpu_rd;
    logic [XLEN-1:0] fpu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [31:0]     busy;
    logic            fregwrite;
    logic [4:0]      frd;
    logic [XLEN-1:0] wdata;

    always #5 clk = ~clk;

    fp_wb_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fpu_valid_i      (fpu_valid),
        .fpu_ready_o      (fpu_ready),
        .fpu_rd_i         (fpu_rd),
        .fpu_data_i       (fpu_data),
        .ld_valid_i       (ld_valid),
        .ld_ready_o       (ld_ready),
        .ld_rd_i          (ld_rd),
        .ld_data_i        (ld_data),
        .issue_valid_i    (issue_valid),
        .issue_rd_i       (issue_rd),
        .busy_o           (busy),
        .fregwrite_o      (fregwrite),
        .frd_o            (frd),
        .writeback_data_o (wdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus sources and reference model state
    wr_t         fpu_src[$];
    wr_t         ld_src[$];
    wr_t         fq[$];
    wr_t         exp_q[$];
    logic [1:0]  m_starve = 2'd0;
    logic [31:0] m_busy   = 32'd0;
    logic        m_wb_vld = 1'b0;
    logic [4:0]  m_wb_rd  = 5'd0;
    wr_t         m_last   = '0;
    logic        iss_v    = 1'b0;
    logic [4:0]  iss_rd   = 5'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        exp_q.delete();
        fpu_src.delete();
        ld_src.delete();
        m_starve = 2'd0;
        m_busy   = 32'd0;
        m_wb_vld = 1'b0;
        m_wb_rd  = 5'd0;
        m_last   = '0;
        iss_v    = 1'b0;
    endtask

    // Called at the falling edge. Compares the DUT outputs with the model.
    task automatic check_outputs();
        wr_t w;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("fregwrite", 64'(fregwrite), 64'd1);
            check("frd", 64'(frd), 64'(w.rd));
            check("wdata", 64'(wdata), 64'(w.data));
            m_wb_vld = 1'b1;
            m_wb_rd  = w.rd;
            m_last   = w;
        end else begin
            check("fregwrite_idle", 64'(fregwrite), 64'd0);
            check("frd_hold", 64'(frd), 64'(m_last.rd));
            check("wdata_hold", 64'(wdata), 64'(m_last.data));
            m_wb_vld = 1'b0;
        end
        check("busy", 64'(busy), 64'(m_busy));
        check("fpu_ready", 64'(fpu_ready), 64'(fq.size() < DEPTH));
        check("ld_ready", 64'(ld_ready), 64'(m_starve != 2'd3));
    endtask

    // One clock cycle. Starts and ends at a falling edge.
    task automatic cycle();
        logic lacc, facc, byp, head;
        int   n0;
        check_outputs();
        fpu_valid   = (fpu_src.size() > 0);
        fpu_rd      = fpu_valid ? fpu_src[0].rd   : 5'd0;
        fpu_data    = fpu_valid ? fpu_src[0].data : '0;
        ld_valid    = (ld_src.size() > 0);
        ld_rd       = ld_valid ? ld_src[0].rd   : 5'd0;
        ld_data     = ld_valid ? ld_src[0].data : '0;
        issue_valid = iss_v;
        issue_rd    = iss_rd;

        n0   = fq.size();
        lacc = ld_valid && (m_starve != 2'd3);
        facc = fpu_valid && (n0 < DEPTH);
        byp  = 1'b0;
`ifdef FP_WB_BYPASS_EN
        byp  = (n0 == 0) && fpu_valid && !lacc;
`endif
        head = (n0 > 0) && !lacc;

        @(posedge clk);
        if (lacc) begin
            exp_q.push_back(ld_src.pop_front());
        end else if (head) begin
            exp_q.push_back(fq.pop_front());
        end else if (byp) begin
            exp_q.push_back(fpu_src[0]);
        end
        if (facc) begin
            if (!byp) fq.push_back(fpu_src[0]);
            void'(fpu_src.pop_front());
        end
        if (n0 == 0)      m_starve = 2'd0;
        else if (lacc)    m_starve = m_starve + 2'd1;
        else              m_starve = 2'd0;
        if (m_wb_vld) m_busy[m_wb_rd] = 1'b0;
        if (iss_v)    m_busy[iss_rd]  = 1'b1;
        iss_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((fpu_src.size() > 0 || ld_src.size() > 0 || fq.size() > 0 ||
                exp_q.size() > 0) && k < 400) begin
            cycle();
            k++;
        end
        cycle();
        check(tag, 64'(k < 400), 64'd1);
    endtask

    initial begin
        wr_t w;
        rst_n       = 1'b0;
        fpu_valid   = 1'b0;
        fpu_rd      = 5'd0;
        fpu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fregwrite", 64'(fregwrite), 64'd0);
        check("rst_frd", 64'(frd), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fpu_ready", 64'(fpu_ready), 64'd1);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        rst_n = 1'b1;
        model_reset();

        // Single FPU result to f5 after issue
        iss_v = 1'b1; iss_rd = 5'd5;
        cycle();
        check("busy5_set", 64'(busy[5]), 64'd1);
        fpu_src.push_back('{rd: 5'd5, data: 32'h3F80_0000});
        drain("drain_single");
        check("busy5_clear", 64'(busy[5]), 64'd0);

        // Fill the FIFO under sustained load traffic
        for (int i = 0; i < 8; i++)
            fpu_src.push_back('{rd: 5'(16 + i), data: 32'hF000_0000 + i});
        for (int i = 0; i < 16; i++)
            ld_src.push_back('{rd: 5'(i), data: 32'hA000_0000 + i});
        drain("drain_starve");

        // Issue to f7 in the cycle where the write to f7 completes
        iss_v = 1'b1; iss_rd = 5'd7;
        cycle();
        ld_src.push_back('{rd: 5'd7, data: 32'h1234_5678});
        cycle();
        iss_v = 1'b1; iss_rd = 5'd7;
        cycle();
        cycle();
        check("busy7_set_wins", 64'(busy[7]), 64'd1);

        // Back-to-back FPU results: simultaneous enqueue/dequeue, pointer wrap
        for (int i = 0; i < 24; i++)
            fpu_src.push_back('{rd: 5'(i), data: $urandom});
        drain("drain_stream");

        // Random traffic
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 2) != 0 && fpu_src.size() < 4)
                fpu_src.push_back('{rd: 5'($urandom_range(0, 31)), data: $urandom});
            if ($urandom_range(0, 2) == 0 && ld_src.size() < 4)
                ld_src.push_back('{rd: 5'($urandom_range(0, 31)), data: $urandom});
            if ($urandom_range(0, 3) == 0) begin
                iss_v  = 1'b1;
                iss_rd = 5'($urandom_range(0, 31));
            end
            cycle();
        end
        drain("drain_random");

        // Reset with 3 entries queued and a write pending
        iss_v = 1'b1; iss_rd = 5'd9;
        cycle();
        for (int i = 0; i < 3; i++)
            fpu_src.push_back('{rd: 5'(20 + i), data: 32'hC000_0000 + i});
        for (int i = 0; i < 4; i++)
            ld_src.push_back('{rd: 5'(24 + i), data: 32'hD000_0000 + i});
        repeat (3) cycle();
        check("pre_rst_queued", 64'(fq.size()), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fregwrite", 64'(fregwrite), 64'd0);
        check("arst_frd", 64'(frd), 64'd0);
        check("arst_wdata", 64'(wdata), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_fpu_ready", 64'(fpu_ready), 64'd1);
        check("arst_ld_ready", 64'(ld_ready), 64'd1);
        model_reset();
        fpu_valid = 1'b0;
        ld_valid  = 1'b0;
        issue_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
